collapse_bank_reader: RTL and testbench

Initiator-side controller for a bank of entangled collapse-register cells: it turns single load/read requests into one-cycle `init`/`read` strobes on the addressed cell and captures that cell's same-cycle `value_out` when `output_enable` pulses. It also owns the entanglement fabric, driving each cell's `peer_collapsed` from its partner's `self_collapsed` plus a bank-wide abort. It sits between the host request bus and the cell array.

---
 rtl/collapse_pkg.sv | 38 +++
 rtl/collapse_bank_reader_fabric.sv | 51 +++++
 rtl/collapse_bank_reader.sv | 183 ++++++++++++++++++
 tb/tb_collapse_bank_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/collapse_pkg.sv
// Shared types and constants for the collapse-register bank reader.
package collapse_pkg;

  localparam int unsigned CELL_W  = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;
  localparam int unsigned POP_W   = 5;  // popcount of up to 16 cells

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_READ = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_COLLAPSED = 2'b01,
    ST_BADIDX    = 2'b10,
    ST_ABORTED   = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_STROBE = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  // Add a small increment to the collapse counter, clamping at CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [POP_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + (CNT_W + 1)'(inc);
    if (sum > (CNT_W + 1)'(CNT_MAX)) begin
      return CNT_W'(CNT_MAX);
    end
    return sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/collapse_bank_reader_fabric.sv
// Entanglement fabric: sticky abort latch, partner mapping of collapse
// flags, rising-edge detection and the saturating collapse counter.
module collapse_peer_fabric
  import collapse_pkg::*;
#(
  parameter int unsigned N_CELLS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               abort,
  input  logic [N_CELLS-1:0] self_collapsed,
  output logic [N_CELLS-1:0] peer_collapsed_c,
  output logic [N_CELLS-1:0] rise_c,
  output logic               abort_latched,
  output logic [CNT_W-1:0]   collapse_count
);

  logic [N_CELLS-1:0] self_q;
  logic [POP_W-1:0]   rise_cnt_c;

  // Each cell sees its pair partner's collapse flag, forced high after abort.
  for (genvar g = 0; g < N_CELLS; g++) begin : g_peer
    assign peer_collapsed_c[g] = self_collapsed[g ^ 1] | abort_latched;
  end

  assign rise_c = self_collapsed & ~self_q;

  // Number of cells that collapsed this cycle.
  always_comb begin
    rise_cnt_c = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      rise_cnt_c = rise_cnt_c + POP_W'(rise_c[i]);
    end
  end

  // Registered copy for edge detection, sticky abort, saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      self_q         <= '0;
      abort_latched  <= 1'b0;
      collapse_count <= '0;
    end else begin
      self_q         <= self_collapsed;
      collapse_count <= sat_add(collapse_count, rise_cnt_c);
      if (abort) begin
        abort_latched <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/collapse_bank_reader.sv
// Initiator-side controller for a bank of entangled collapse-register cells.
// Turns single LOAD/READ requests into one-cycle init/read strobes, captures
// the addressed cell's result and tracks which cells are known collapsed.
// Optional build macro: COLLAPSE_READER_SCRUB_EN clears rsp_data on the
// response handshake edge; without it rsp_data holds until the next response.
module collapse_bank_reader
  import collapse_pkg::*;
#(
  parameter int unsigned N_CELLS = 4,
  parameter int unsigned IDX_W   = $clog2(N_CELLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_op,
  input  logic [IDX_W-1:0]          req_idx,
  input  logic [CELL_W-1:0]         req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CELL_W-1:0]         rsp_data,
  output logic [1:0]                rsp_status,
  input  logic                      abort,
  output logic [N_CELLS-1:0]        cell_init,
  output logic [N_CELLS-1:0]        cell_read,
  output logic [CELL_W-1:0]         cell_value_in,
  input  logic [CELL_W*N_CELLS-1:0] cell_value_out,
  input  logic [N_CELLS-1:0]        cell_oe,
  input  logic [N_CELLS-1:0]        cell_self_collapsed,
  output logic [N_CELLS-1:0]        cell_peer_collapsed,
  output logic [N_CELLS-1:0]        consumed_mask,
  output logic [CNT_W-1:0]          collapse_count
);

  state_e             state;
  op_e                op_q;
  logic [IDX_W-1:0]   idx_q;

  logic               abort_latched;
  logic [N_CELLS-1:0] rise_c;

  logic               req_idx_ok_c;
  logic [N_CELLS-1:0] req_onehot_c;
  logic [N_CELLS-1:0] sel_onehot_c;
  logic [CELL_W-1:0]  sel_value_c;
  logic               sel_oe_c;
  logic               sel_self_c;
  logic               sel_peer_c;

  collapse_peer_fabric #(
    .N_CELLS (N_CELLS)
  ) u_fabric (
    .clk              (clk),
    .reset            (reset),
    .abort            (abort),
    .self_collapsed   (cell_self_collapsed),
    .peer_collapsed_c (cell_peer_collapsed),
    .rise_c           (rise_c),
    .abort_latched    (abort_latched),
    .collapse_count   (collapse_count)
  );

  // Decode the incoming request index; IDX_W may exceed the cell range.
  always_comb begin
    req_idx_ok_c = (32'(req_idx) < N_CELLS);
    req_onehot_c = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (32'(req_idx) == 32'(i)) begin
        req_onehot_c[i] = 1'b1;
      end
    end
  end

  // Select the latched cell's result lines for the STROBE-exit sample.
  always_comb begin
    sel_onehot_c = '0;
    sel_value_c  = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (32'(idx_q) == 32'(i)) begin
        sel_onehot_c[i] = 1'b1;
        sel_value_c     = cell_value_out[i*CELL_W +: CELL_W];
      end
    end
  end

  assign sel_oe_c   = |(cell_oe & sel_onehot_c);
  assign sel_self_c = |(cell_self_collapsed & sel_onehot_c);
  assign sel_peer_c = |(cell_peer_collapsed & sel_onehot_c);

  // Request FSM with registered strobes and response; rsp_data doubles as
  // the capture register for the read value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      op_q          <= OP_LOAD;
      idx_q         <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_status    <= ST_OK;
      cell_init     <= '0;
      cell_read     <= '0;
      cell_value_in <= '0;
      consumed_mask <= '0;
    end else begin
      consumed_mask <= consumed_mask | rise_c;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            op_q      <= op_e'(req_op);
            idx_q     <= req_idx;
            if (abort_latched) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_ABORTED;
              rsp_data   <= '0;
            end else if (!req_idx_ok_c) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BADIDX;
              rsp_data   <= '0;
            end else begin
              state         <= S_STROBE;
              cell_value_in <= req_data;
              if (req_op) begin
                cell_read <= req_onehot_c;
              end else begin
                cell_init <= req_onehot_c;
              end
            end
          end
        end

        S_STROBE: begin
          cell_init <= '0;
          cell_read <= '0;
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          if (op_q == OP_READ) begin
            // A read always consumes the cell, whether or not it answered.
            consumed_mask <= consumed_mask | rise_c | sel_onehot_c;
            if (sel_oe_c) begin
              rsp_status <= ST_OK;
              rsp_data   <= sel_value_c;
            end else begin
              rsp_status <= ST_COLLAPSED;
              rsp_data   <= '0;
            end
          end else begin
            rsp_data <= '0;
            if (sel_self_c || sel_peer_c) begin
              rsp_status    <= ST_COLLAPSED;
              consumed_mask <= consumed_mask | rise_c | sel_onehot_c;
            end else begin
              rsp_status <= ST_OK;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
`ifdef COLLAPSE_READER_SCRUB_EN
            rsp_data  <= '0;
`endif
          end
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          cell_init <= '0;
          cell_read <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collapse_bank_reader.sv
// Self-checking bench for collapse_bank_reader (N_CELLS=4, IDX_W=3 so that
// out-of-range indices are representable). The bench plays the cell array.
module tb_collapse_bank_reader;

  localparam logic [1:0] E_OK   = 2'b00;
  localparam logic [1:0] E_COLL = 2'b01;
  localparam logic [1:0] E_BAD  = 2'b10;
  localparam logic [1:0] E_ABT  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [2:0]  req_idx;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic        abort;
  logic [3:0]  cell_init;
  logic [3:0]  cell_read;
  logic [7:0]  cell_value_in;
  logic [31:0] vals;
  logic [3:0]  oe;
  logic [3:0]  selfv;
  logic [3:0]  cell_peer_collapsed;
  logic [3:0]  consumed_mask;
  logic [7:0]  collapse_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [3:0] m_prev;
  logic [3:0] m_consumed;
  int         m_count;
  logic       m_abort;

  typedef struct {
    logic       op;
    logic [2:0] idx;
    logic [7:0] data;
    logic [3:0] oe;
    logic [31:0] vals;
    logic [3:0] selfv;
    logic [3:0] peer;
    int         hold;
    logic [1:0] es;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  collapse_bank_reader #(.N_CELLS(4), .IDX_W(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op              (req_op),
    .req_idx             (req_idx),
    .req_data            (req_data),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_status          (rsp_status),
    .abort               (abort),
    .cell_init           (cell_init),
    .cell_read           (cell_read),
    .cell_value_in       (cell_value_in),
    .cell_value_out      (vals),
    .cell_oe             (oe),
    .cell_self_collapsed (selfv),
    .cell_peer_collapsed (cell_peer_collapsed),
    .consumed_mask       (consumed_mask),
    .collapse_count      (collapse_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; the model absorbs what the DUT samples at that edge.
  task automatic tick();
    logic [3:0] r;
    int s;
    r = selfv & ~m_prev;
    m_prev = selfv;
    m_consumed = m_consumed | r;
    s = m_count + $countones(r);
    m_count = (s > 255) ? 255 : s;
    if (abort) m_abort = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_idx = '0; req_data = '0;
    rsp_ready = 1'b0; abort = 1'b0;
    selfv = '0; oe = '0; vals = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_prev = '0; m_consumed = '0; m_count = 0; m_abort = 1'b0;
  endtask

  // One full request/response transaction with cell inputs held constant.
  task automatic do_req(input string tag, input logic op, input logic [2:0] idx,
                        input logic [7:0] data, input int hold, input logic abort_mid,
                        input logic [1:0] es, input logic [7:0] ed);
    logic strobe_exp;
    logic [3:0] oh;
    logic [7:0] post;
    oh = 4'b0001 << idx[1:0];
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    strobe_exp = !m_abort && (idx < 3'd4);
    req_valid = 1'b1; req_op = op; req_idx = idx; req_data = data;
    tick();
    req_valid = 1'b0;
    if (strobe_exp) begin
      chk({tag, " init"}, 32'(cell_init), 32'(op ? 4'b0000 : oh));
      chk({tag, " read"}, 32'(cell_read), 32'(op ? oh : 4'b0000));
      chk({tag, " value_in"}, 32'(cell_value_in), 32'(data));
      chk({tag, " early rsp_valid"}, 32'(rsp_valid), 32'd0);
      if (abort_mid) abort = 1'b1;
      tick();
      abort = 1'b0;
      if (op || es == E_COLL) m_consumed = m_consumed | oh;
    end else begin
      chk({tag, " no strobe"}, 32'({cell_init, cell_read}), 32'd0);
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " status"}, 32'(rsp_status), 32'(es));
    chk({tag, " data"}, 32'(rsp_data), 32'(ed));
    chk({tag, " strobes idle"}, 32'({cell_init, cell_read}), 32'd0);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, " hold"}, 32'({rsp_valid, rsp_status, rsp_data}), 32'({1'b1, es, ed}));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef COLLAPSE_READER_SCRUB_EN
    post = 8'h00;
`else
    post = ed;
`endif
    chk({tag, " after hs"}, 32'({rsp_valid, req_ready}), 32'b01);
    chk({tag, " post data"}, 32'(rsp_data), 32'(post));
    chk({tag, " consumed"}, 32'(consumed_mask), 32'(m_consumed));
    chk({tag, " count"}, 32'(collapse_count), 32'(m_count));
  endtask

  initial begin
    logic       op;
    logic [2:0] idx;
    logic [7:0] data;
    logic [1:0] es;
    logic [7:0] ed;
    int         hold;

    // directed vectors: LOAD/READ pair, collapse, bad index, partner effects
    tbl[0] = '{op:1'b0, idx:3'd1, data:8'h3C, oe:4'b0000, vals:32'h0000_0000, selfv:4'b0000, peer:4'b0000, hold:0, es:E_OK,   ed:8'h00};
    tbl[1] = '{op:1'b1, idx:3'd1, data:8'h00, oe:4'b0010, vals:32'h0000_3C00, selfv:4'b0000, peer:4'b0000, hold:5, es:E_OK,   ed:8'h3C};
    tbl[2] = '{op:1'b1, idx:3'd1, data:8'h00, oe:4'b0000, vals:32'h0000_0000, selfv:4'b0010, peer:4'b0001, hold:0, es:E_COLL, ed:8'h00};
    tbl[3] = '{op:1'b1, idx:3'd0, data:8'h00, oe:4'b0000, vals:32'h0000_0000, selfv:4'b0011, peer:4'b0011, hold:1, es:E_COLL, ed:8'h00};
    tbl[4] = '{op:1'b1, idx:3'd5, data:8'h00, oe:4'b0000, vals:32'h0000_0000, selfv:4'b0011, peer:4'b0011, hold:0, es:E_BAD,  ed:8'h00};
    tbl[5] = '{op:1'b0, idx:3'd3, data:8'hA5, oe:4'b0000, vals:32'h0000_0000, selfv:4'b0011, peer:4'b0011, hold:0, es:E_OK,   ed:8'h00};
    tbl[6] = '{op:1'b0, idx:3'd2, data:8'h5A, oe:4'b0000, vals:32'h0000_0000, selfv:4'b1011, peer:4'b0111, hold:0, es:E_COLL, ed:8'h00};
    tbl[7] = '{op:1'b1, idx:3'd3, data:8'h00, oe:4'b1000, vals:32'h7700_0000, selfv:4'b1011, peer:4'b0111, hold:2, es:E_OK,   ed:8'h77};

    // reset values, checked while reset is still asserted
    reset = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_idx = '0; req_data = '0;
    rsp_ready = 1'b0; abort = 1'b0; selfv = '0; oe = '0; vals = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp", 32'({rsp_valid, rsp_status, rsp_data}), 32'd0);
    chk("reset strobes", 32'({cell_init, cell_read, cell_value_in}), 32'd0);
    chk("reset masks", 32'({consumed_mask, collapse_count}), 32'd0);
    chk("reset peer", 32'(cell_peer_collapsed), 32'd0);
    do_reset();

    for (int t = 0; t < 8; t++) begin
      selfv = tbl[t].selfv; oe = tbl[t].oe; vals = tbl[t].vals;
      #1;
      chk($sformatf("v%0d peer", t), 32'(cell_peer_collapsed), 32'(tbl[t].peer));
      do_req($sformatf("v%0d", t), tbl[t].op, tbl[t].idx, tbl[t].data, tbl[t].hold,
             1'b0, tbl[t].es, tbl[t].ed);
    end
    chk("table count", 32'(collapse_count), 32'd3);
    chk("table consumed", 32'(consumed_mask), 32'hF);

    // randomized transactions against the reference model
    do_reset();
    for (int k = 0; k < 40; k++) begin
      op   = 1'($urandom_range(0, 1));
      idx  = 3'($urandom_range(0, 5));
      data = 8'($urandom);
      hold = int'($urandom_range(0, 2));
      oe   = 4'($urandom);
      vals = $urandom;
      if ($urandom_range(0, 3) == 0) selfv = 4'($urandom);
      if (idx >= 3'd4) begin
        es = E_BAD; ed = 8'h00;
      end else if (op) begin
        es = oe[idx[1:0]] ? E_OK : E_COLL;
        ed = oe[idx[1:0]] ? vals[{idx[1:0], 3'b000} +: 8] : 8'h00;
      end else begin
        es = (selfv[idx[1:0]] | selfv[idx[1:0] ^ 2'd1] | m_abort) ? E_COLL : E_OK;
        ed = 8'h00;
      end
      do_req($sformatf("r%0d", k), op, idx, data, hold, 1'b0, es, ed);
    end

    // abort during STROBE: result stands, peers rise afterwards, later requests abort
    do_reset();
    chk("pre-abort peer", 32'(cell_peer_collapsed), 32'd0);
    do_req("abort_mid", 1'b0, 3'd2, 8'h11, 0, 1'b1, E_OK, 8'h00);
    chk("abort peer", 32'(cell_peer_collapsed), 32'hF);
    do_req("aborted load", 1'b0, 3'd2, 8'h22, 0, 1'b0, E_ABT, 8'h00);
    do_req("aborted badidx", 1'b1, 3'd7, 8'h00, 1, 1'b0, E_ABT, 8'h00);

    // reset in the middle of a strobe drops it immediately
    do_reset();
    req_valid = 1'b1; req_op = 1'b0; req_idx = 3'd0; req_data = 8'h99;
    tick();
    req_valid = 1'b0;
    chk("midrst strobe", 32'(cell_init), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst cleared", 32'({cell_init, cell_read, cell_value_in, rsp_valid}), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd1);
    do_reset();
    oe = 4'b0001; vals = 32'h0000_0042;
    do_req("after midrst", 1'b1, 3'd0, 8'h00, 0, 1'b0, E_OK, 8'h42);

    // forced repeated edges drive the counter into saturation
    do_reset();
    for (int k = 0; k < 70; k++) begin
      selfv = 4'hF; tick();
      selfv = 4'h0; tick();
      if (k == 9) chk("count 40", 32'(collapse_count), 32'd40);
    end
    chk("count sat", 32'(collapse_count), 32'd255);
    chk("count model", 32'(collapse_count), 32'(m_count));
    chk("sat consumed", 32'(consumed_mask), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
